// File: rtl/bus_send_ctrl_pkg.sv
// Shared definitions for the bus send controller: instruction classes,
// fetch step positions and the per-class last-active-step lookup.
package bus_send_ctrl_pkg;

  // Class 0..7 come straight from the 3-bit class field; ALU is flagged by the MSB.
  typedef enum logic [3:0] {
    CLS_LD   = 4'd0,
    CLS_ST   = 4'd1,
    CLS_DATA = 4'd2,
    CLS_JMPR = 4'd3,
    CLS_JMP  = 4'd4,
    CLS_JCON = 4'd5,
    CLS_CLR  = 4'd6,
    CLS_DISP = 4'd7,
    CLS_ALU  = 4'd8
  } instr_class_e;

  // Fetch step numbers (1-based) shared by every instruction.
  localparam int STEP_FETCH_IAR = 1;
  localparam int STEP_FETCH_RAM = 2;
  localparam int STEP_FETCH_ACC = 3;
  localparam int STEP_IR_LATCH  = 2;

  // Last step that drives anything on the bus for a given class.
  function automatic int last_active_step(instr_class_e cls);
    case (cls)
      CLS_ALU, CLS_DATA, CLS_JCON: last_active_step = 6;
      CLS_LD, CLS_ST, CLS_JMP:     last_active_step = 5;
      default:                     last_active_step = 4;
    endcase
  endfunction

endpackage

// File: rtl/bus_send_ctrl_step_ring.sv
// One-hot ring counter for the instruction sequencer. Holds while hold=1,
// otherwise advances one position per clock and returns to the first
// position after the last one or whenever wrap is requested.
module step_ring #(
  parameter int NSTEPS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              wrap,
  output logic [NSTEPS-1:0] ring
);

  localparam logic [NSTEPS-1:0] RING_HOME = {{(NSTEPS-1){1'b0}}, 1'b1};

  // Advance, hold or wrap the one-hot position.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring <= RING_HOME;
    end else if (!hold) begin
      if (wrap || ring[NSTEPS-1]) begin
        ring <= RING_HOME;
      end else begin
        ring <= ring << 1;
      end
    end
  end

endmodule

// File: rtl/bus_send_ctrl.sv
// Bus send-enable controller: sequences the steps of each instruction and
// decides which source (bus-1, IAR, RAM, ACC or a general register) drives
// the shared bus, masking internal drivers that would fight an external one.
module bus_send_ctrl
  import bus_send_ctrl_pkg::*;
#(
  parameter  int NSTEPS    = 6,
  parameter  int NREG      = 4,
  parameter  int EARLY_END = 0,
  localparam int RW        = $clog2(NREG),
  localparam int IRW       = 4 + 2 * RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [IRW-1:0]    ir,
  input  logic              ext_drive,
  output logic              o_bus1,
  output logic              o_iar,
  output logic              o_ram,
  output logic              o_acc,
  output logic [NREG-1:0]   o_reg,
  output logic [NSTEPS-1:0] step,
  output logic              instr_done,
  output logic              bus_conflict
);

  logic [IRW-1:0]  ir_q;
  instr_class_e    cls;
  logic [RW-1:0]   ra;
  logic [RW-1:0]   rb;
  logic [NREG-1:0] ra_oh;
  logic [NREG-1:0] rb_oh;
  logic            bus1_raw;
  logic            iar_raw;
  logic            ram_raw;
  logic            acc_raw;
  logic [NREG-1:0] reg_raw;
  logic            last_hit;
  logic            done_raw;
  logic            early_wrap;
  logic            active;
  logic            src_any;
  logic            conflict_now;
  logic            gate;

  step_ring #(
    .NSTEPS(NSTEPS)
  ) u_step_ring (
    .clk  (clk),
    .rst  (rst),
    .hold (stall),
    .wrap (early_wrap),
    .ring (step)
  );

  // Field extraction from the latched instruction word.
  always_comb begin
    if (ir_q[IRW-1]) begin
      cls = CLS_ALU;
    end else begin
      cls = instr_class_e'({1'b0, ir_q[IRW-2:IRW-4]});
    end
    ra = ir_q[2*RW-1:RW];
    rb = ir_q[RW-1:0];
    ra_oh = '0;
    ra_oh[ra] = 1'b1;
    rb_oh = '0;
    rb_oh[rb] = 1'b1;
  end

  // Unmasked enable decode from the current step and instruction class.
  always_comb begin
    bus1_raw = 1'b0;
    iar_raw  = 1'b0;
    ram_raw  = 1'b0;
    acc_raw  = 1'b0;
    reg_raw  = '0;
    if (step[STEP_FETCH_IAR-1]) begin
      bus1_raw = 1'b1;
      iar_raw  = 1'b1;
    end
    if (step[STEP_FETCH_RAM-1]) ram_raw = 1'b1;
    if (step[STEP_FETCH_ACC-1]) acc_raw = 1'b1;
    if (step[3]) begin
      case (cls)
        CLS_ALU, CLS_JMPR, CLS_DISP: reg_raw = rb_oh;
        CLS_LD, CLS_ST:              reg_raw = ra_oh;
        CLS_DATA, CLS_JCON: begin
          bus1_raw = 1'b1;
          iar_raw  = 1'b1;
        end
        CLS_JMP:                     iar_raw = 1'b1;
        CLS_CLR:                     bus1_raw = 1'b1;
        default: ;
      endcase
    end
    if (step[4]) begin
      case (cls)
        CLS_ALU:                    reg_raw = ra_oh;
        CLS_ST:                     reg_raw = rb_oh;
        CLS_LD, CLS_DATA, CLS_JMP:  ram_raw = 1'b1;
        CLS_JCON:                   acc_raw = 1'b1;
        default: ;
      endcase
    end
    if (step[5]) begin
      case (cls)
        CLS_ALU, CLS_DATA: acc_raw = 1'b1;
        CLS_JCON:          ram_raw = 1'b1;
        default: ;
      endcase
    end
  end

  // End-of-instruction detection; fetch steps never match since the last active step is at least 4.
  always_comb begin
    last_hit = 1'b0;
    for (int i = 0; i < NSTEPS; i++) begin
      if (step[i] && ((i + 1) == last_active_step(cls))) last_hit = 1'b1;
    end
    if (EARLY_END != 0) begin
      done_raw = last_hit;
    end else begin
      done_raw = step[NSTEPS-1];
    end
    early_wrap = (EARLY_END != 0) && last_hit;
  end

  // Output masking: stall/reset kill everything, an external driver kills internal sources.
  always_comb begin
    active       = !stall && !rst;
    src_any      = iar_raw || ram_raw || acc_raw || (|reg_raw);
    conflict_now = active && ext_drive && src_any;
    gate         = active && !ext_drive;
    o_bus1       = active && bus1_raw;
    o_iar        = gate && iar_raw;
    o_ram        = gate && ram_raw;
    o_acc        = gate && acc_raw;
    o_reg        = gate ? reg_raw : '0;
    instr_done   = active && done_raw;
  end

  // Instruction latch at the end of the IR-load step and sticky conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q         <= '0;
      bus_conflict <= 1'b0;
    end else begin
      if (step[STEP_IR_LATCH-1] && !stall) ir_q <= ir;
      if (conflict_now) bus_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_send_ctrl.sv
// Testbench for bus_send_ctrl: a vector table on the default configuration
// plus short hand sequences for early-end and the wide 8-register/8-step build.
module tb_bus_send_ctrl;

  typedef struct packed {
    logic        bus1;
    logic        iar;
    logic        ram;
    logic        acc;
    logic [7:0]  regs;
    logic [15:0] step;
    logic        done;
    logic        conflict;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       stall;
    logic       ext;
    logic [9:0] ir;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_v = 1'b1;
  logic       stall_v = 1'b0;
  logic       ext_v = 1'b0;
  logic [9:0] ir_v = '0;

  logic       a_bus1, a_iar, a_ram, a_acc, a_done, a_conf;
  logic [3:0] a_reg;
  logic [5:0] a_step;
  logic       e_bus1, e_iar, e_ram, e_acc, e_done, e_conf;
  logic [3:0] e_reg;
  logic [5:0] e_step;
  logic       w_bus1, w_iar, w_ram, w_acc, w_done, w_conf;
  logic [7:0] w_reg;
  logic [7:0] w_step;

  int   n_applied = 0;
  int   n_miss = 0;
  out_t exp_q[$];
  vec_t vecs[29];

  always #5 clk = ~clk;

  bus_send_ctrl dut_a (
    .clk(clk), .rst(rst_v), .stall(stall_v), .ir(ir_v[7:0]), .ext_drive(ext_v),
    .o_bus1(a_bus1), .o_iar(a_iar), .o_ram(a_ram), .o_acc(a_acc), .o_reg(a_reg),
    .step(a_step), .instr_done(a_done), .bus_conflict(a_conf)
  );

  bus_send_ctrl #(.EARLY_END(1)) dut_e (
    .clk(clk), .rst(rst_v), .stall(stall_v), .ir(ir_v[7:0]), .ext_drive(ext_v),
    .o_bus1(e_bus1), .o_iar(e_iar), .o_ram(e_ram), .o_acc(e_acc), .o_reg(e_reg),
    .step(e_step), .instr_done(e_done), .bus_conflict(e_conf)
  );

  bus_send_ctrl #(.NSTEPS(8), .NREG(8), .EARLY_END(0)) dut_w (
    .clk(clk), .rst(rst_v), .stall(stall_v), .ir(ir_v), .ext_drive(ext_v),
    .o_bus1(w_bus1), .o_iar(w_iar), .o_ram(w_ram), .o_acc(w_acc), .o_reg(w_reg),
    .step(w_step), .instr_done(w_done), .bus_conflict(w_conf)
  );

  function automatic out_t mk(logic b1, logic ia, logic rm, logic ac, logic [7:0] rg,
                              int sn, logic dn, logic cf);
    out_t o;
    o.bus1 = b1;
    o.iar = ia;
    o.ram = rm;
    o.acc = ac;
    o.regs = rg;
    o.step = 16'(1) << (sn - 1);
    o.done = dn;
    o.conflict = cf;
    return o;
  endfunction

  function automatic vec_t mkv(logic r, logic s, logic e, logic [9:0] i, out_t x);
    vec_t v;
    v.rst = r;
    v.stall = s;
    v.ext = e;
    v.ir = i;
    v.exp = x;
    return v;
  endfunction

  function automatic out_t actual(int sel);
    out_t o;
    case (sel)
      0: o = {a_bus1, a_iar, a_ram, a_acc, {4'b0, a_reg}, {10'b0, a_step}, a_done, a_conf};
      1: o = {e_bus1, e_iar, e_ram, e_acc, {4'b0, e_reg}, {10'b0, e_step}, e_done, e_conf};
      default: o = {w_bus1, w_iar, w_ram, w_acc, w_reg, {8'b0, w_step}, w_done, w_conf};
    endcase
    return o;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic apply(input int sel, input vec_t v, input string name);
    out_t ex;
    out_t got;
    @(posedge clk);
    #1;
    rst_v = v.rst;
    stall_v = v.stall;
    ext_v = v.ext;
    ir_v = v.ir;
    exp_q.push_back(v.exp);
    @(negedge clk);
    ex = exp_q.pop_front();
    got = actual(sel);
    n_applied++;
    if (got !== ex) begin
      n_miss++;
      $display("FAIL %s: got bus1=%b iar=%b ram=%b acc=%b reg=%h step=%h done=%b conflict=%b; expected bus1=%b iar=%b ram=%b acc=%b reg=%h step=%h done=%b conflict=%b",
               name, got.bus1, got.iar, got.ram, got.acc, got.regs, got.step, got.done, got.conflict,
               ex.bus1, ex.iar, ex.ram, ex.acc, ex.regs, ex.step, ex.done, ex.conflict);
    end
  endtask

  // Unchecked reset cycle so the following checked reset cycle starts from step 1.
  task automatic pre_reset();
    @(posedge clk);
    #1;
    rst_v = 1'b1;
    stall_v = 1'b0;
    ext_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    // Default build, ALU 9B: fetch, RB, RA, ACC; stall at step 4; conflict; reset mid-instruction; LD 06.
    vecs[0]  = mkv(1, 0, 0, 10'h09B, mk(0, 0, 0, 0, 8'h00, 1, 0, 0));
    vecs[1]  = mkv(0, 0, 0, 10'h09B, mk(1, 1, 0, 0, 8'h00, 1, 0, 0));
    vecs[2]  = mkv(0, 0, 0, 10'h09B, mk(0, 0, 1, 0, 8'h00, 2, 0, 0));
    vecs[3]  = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 1, 8'h00, 3, 0, 0));
    vecs[4]  = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 0, 8'h08, 4, 0, 0));
    vecs[5]  = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 0, 8'h04, 5, 0, 0));
    vecs[6]  = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 1, 8'h00, 6, 1, 0));
    vecs[7]  = mkv(0, 0, 0, 10'h09B, mk(1, 1, 0, 0, 8'h00, 1, 0, 0));
    vecs[8]  = mkv(0, 0, 0, 10'h09B, mk(0, 0, 1, 0, 8'h00, 2, 0, 0));
    vecs[9]  = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 1, 8'h00, 3, 0, 0));
    vecs[10] = mkv(0, 1, 0, 10'h09B, mk(0, 0, 0, 0, 8'h00, 4, 0, 0));
    vecs[11] = mkv(0, 1, 0, 10'h09B, mk(0, 0, 0, 0, 8'h00, 4, 0, 0));
    vecs[12] = mkv(0, 1, 0, 10'h09B, mk(0, 0, 0, 0, 8'h00, 4, 0, 0));
    vecs[13] = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 0, 8'h08, 4, 0, 0));
    vecs[14] = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 0, 8'h04, 5, 0, 0));
    vecs[15] = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 1, 8'h00, 6, 1, 0));
    vecs[16] = mkv(0, 0, 0, 10'h09B, mk(1, 1, 0, 0, 8'h00, 1, 0, 0));
    vecs[17] = mkv(0, 0, 1, 10'h09B, mk(0, 0, 0, 0, 8'h00, 2, 0, 0));
    vecs[18] = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 1, 8'h00, 3, 0, 1));
    vecs[19] = mkv(0, 0, 0, 10'h09B, mk(0, 0, 0, 0, 8'h08, 4, 0, 1));
    vecs[20] = mkv(1, 0, 0, 10'h09B, mk(0, 0, 0, 0, 8'h00, 5, 0, 1));
    vecs[21] = mkv(0, 0, 0, 10'h006, mk(1, 1, 0, 0, 8'h00, 1, 0, 0));
    vecs[22] = mkv(0, 0, 0, 10'h006, mk(0, 0, 1, 0, 8'h00, 2, 0, 0));
    vecs[23] = mkv(0, 0, 0, 10'h006, mk(0, 0, 0, 1, 8'h00, 3, 0, 0));
    vecs[24] = mkv(0, 0, 0, 10'h006, mk(0, 0, 0, 0, 8'h02, 4, 0, 0));
    vecs[25] = mkv(0, 0, 0, 10'h006, mk(0, 0, 1, 0, 8'h00, 5, 0, 0));
    vecs[26] = mkv(0, 0, 1, 10'h006, mk(0, 0, 0, 0, 8'h00, 6, 1, 0));
    vecs[27] = mkv(0, 0, 1, 10'h006, mk(1, 0, 0, 0, 8'h00, 1, 0, 0));
    vecs[28] = mkv(0, 0, 0, 10'h006, mk(0, 0, 1, 0, 8'h00, 2, 0, 1));

    rst_v = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 29; i++) begin
      apply(0, vecs[i], $sformatf("dflt_vec%0d", i));
    end

    // Early-end build, LD 06: wraps to step 1 straight after step 5.
    pre_reset();
    apply(1, mkv(1, 0, 0, 10'h006, mk(0, 0, 0, 0, 8'h00, 1, 0, 0)), "early_reset");
    apply(1, mkv(0, 0, 0, 10'h006, mk(1, 1, 0, 0, 8'h00, 1, 0, 0)), "early_s1");
    apply(1, mkv(0, 0, 0, 10'h006, mk(0, 0, 1, 0, 8'h00, 2, 0, 0)), "early_s2");
    apply(1, mkv(0, 0, 0, 10'h006, mk(0, 0, 0, 1, 8'h00, 3, 0, 0)), "early_s3");
    apply(1, mkv(0, 0, 0, 10'h006, mk(0, 0, 0, 0, 8'h02, 4, 0, 0)), "early_s4");
    apply(1, mkv(0, 0, 0, 10'h006, mk(0, 0, 1, 0, 8'h00, 5, 1, 0)), "early_s5_done");
    apply(1, mkv(0, 0, 0, 10'h006, mk(1, 1, 0, 0, 8'h00, 1, 0, 0)), "early_wrap_s1");
    apply(1, mkv(0, 0, 0, 10'h006, mk(0, 0, 1, 0, 8'h00, 2, 0, 0)), "early_wrap_s2");

    // Wide build (8 regs, 8 steps), CLR: bus-1 only at step 4, idle to step 8.
    pre_reset();
    apply(2, mkv(1, 0, 0, 10'h180, mk(0, 0, 0, 0, 8'h00, 1, 0, 0)), "wide_reset");
    apply(2, mkv(0, 0, 0, 10'h180, mk(1, 1, 0, 0, 8'h00, 1, 0, 0)), "wide_s1");
    apply(2, mkv(0, 0, 0, 10'h180, mk(0, 0, 1, 0, 8'h00, 2, 0, 0)), "wide_s2");
    apply(2, mkv(0, 0, 0, 10'h180, mk(0, 0, 0, 1, 8'h00, 3, 0, 0)), "wide_s3");
    apply(2, mkv(0, 0, 0, 10'h180, mk(1, 0, 0, 0, 8'h00, 4, 0, 0)), "wide_s4_clr");
    for (int s = 5; s <= 7; s++) begin
      apply(2, mkv(0, 0, 0, 10'h180, mk(0, 0, 0, 0, 8'h00, s, 0, 0)), $sformatf("wide_s%0d_idle", s));
    end
    apply(2, mkv(0, 0, 0, 10'h180, mk(0, 0, 0, 0, 8'h00, 8, 1, 0)), "wide_s8_done");
    apply(2, mkv(0, 0, 0, 10'h180, mk(1, 1, 0, 0, 8'h00, 1, 0, 0)), "wide_wrap_s1");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_send_ctrl.md
BUS_SEND_CTRL -- requirements
Module: bus_send_ctrl

Interface
REQ-001 SHALL have parameter NSTEPS, default 6, number of sequencer steps per instruction (legal 6..16).
REQ-002 SHALL have parameter NREG, default 4, number of general registers (power of two, 2..8); RW = log2(NREG), IRW = 4 + 2*RW.
REQ-003 SHALL have parameter EARLY_END, default 0: 1 = restart at step 1 after an instruction's last active step; 0 = always run all NSTEPS steps.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  freeze sequencer and mask all enables.
REQ-007 SHALL have port ir  input  IRW  instruction word from IR, sampled at end of step 2.
REQ-008 SHALL have port ext_drive  input  1  external device is driving the bus this cycle.
REQ-009 SHALL have port o_bus1  output  1  force bus-1 into ALU B input.
REQ-010 SHALL have ports o_iar, o_ram, o_acc  output  1 each  enable IAR / RAM / ACC onto the bus.
REQ-011 SHALL have port o_reg  output  NREG  one-hot enable of general register onto the bus.
REQ-012 SHALL have port step  output  NSTEPS  one-hot current step (bit 0 = step 1).
REQ-013 SHALL have port instr_done  output  1  high during the final step of an instruction when not stalled.
REQ-014 SHALL have port bus_conflict  output  1  sticky flag: internal enable collided with ext_drive.

Function
REQ-015 Sequencer SHALL be one-hot over NSTEPS; advances one step per clk when stall=0; holds when stall=1.
REQ-016 After the final step (step NSTEPS, or last active step when EARLY_END=1) sequencer SHALL wrap to step 1.
REQ-017 ir SHALL be latched into ir_q at the clk edge ending step 2 (if not stalled); steps 4..NSTEPS decode ir_q only.
REQ-018 Decode: ir_q[IRW-1]=1 -> ALU; else ir_q[IRW-2:IRW-4] class 0..7 = LD, ST, DATA, JMPR, JMP, JCON, CLR, DISP; RA = ir_q[2RW-1:RW], RB = ir_q[RW-1:0].
REQ-019 Fetch, all classes: step1 o_bus1+o_iar; step2 o_ram; step3 o_acc.
REQ-020 Steps 4/5/6: ALU RB/RA/ACC; LD RA/RAM/-; ST RA/RB/-; DATA bus1+IAR/RAM/ACC; JMPR RB/-/-; JMP IAR/RAM/-; JCON bus1+IAR/ACC/RAM; CLR bus1/-/-; DISP RB/-/-. RA/RB means o_reg bit RA/RB.
REQ-021 Last active step: ALU, DATA, JCON = 6; LD, ST, JMP = 5; JMPR, CLR, DISP = 4; steps above 6 are idle (no enables).
REQ-022 Enables SHALL be combinational from step and ir_q; all enables and instr_done forced 0 while stall=1 or rst=1.
REQ-023 If ext_drive=1 in a cycle where any of o_iar/o_ram/o_acc/o_reg would assert, those enables SHALL be suppressed that cycle and bus_conflict set at next edge; o_bus1 unaffected.
REQ-024 bus_conflict SHALL remain 1 until rst; ext_drive with no internal source is not a conflict.
REQ-025 At most one of o_iar/o_ram/o_acc/o_reg bits SHALL be high in any cycle.

Reset
REQ-026 On rst at a clk edge: step = step 1, ir_q = 0, bus_conflict = 0, regardless of current step or stall.
REQ-027 First cycle after rst deasserts SHALL present step 1 enables (o_bus1=1, o_iar=1).

Structure
REQ-028 Shared package SHALL hold instruction-class enum, fetch step constants, and last-active-step lookup function.
REQ-029 One sub-module step_ring (parametrised one-hot ring counter with hold and early-wrap inputs) SHALL implement the sequencer.

Verification
REQ-030 Defaults, ir=8'h9B (ALU, RA=2, RB=3): steps 1..6 give bus1+iar, ram, acc, o_reg=4'b1000, o_reg=4'b0100, acc; instr_done at step 6.
REQ-031 ir=8'h06 (LD, RA=1, RB=2): step4 o_reg=4'b0010, step5 o_ram; EARLY_END=1 -> step 1 next cycle; EARLY_END=0 -> step 6 idle then step 1.
REQ-032 stall=1 for 3 cycles entering step 4: step held at 4'b1000 bit, all enables 0; resumes step 4 enables, then 5.
REQ-033 ext_drive=1 during step 2: o_ram=0 that cycle, bus_conflict=1 next cycle and stays 1 until rst.
REQ-034 rst pulsed during step 5 of ALU: enables 0 during rst, next cycle step 1 with ir_q=0, bus_conflict=0.
REQ-035 NREG=8, NSTEPS=8, EARLY_END=0, ir=10'b0110000000 (CLR): step4 o_bus1 only, steps 5..8 idle, instr_done at step 8.
